// File: rtl/ysyx_22041461_pipe_stage.sv
// ysyx_22041461_pipe_stage: elastic valid/ready pipeline register.
// A two-entry skid buffer (main + skid) keeps one transfer per cycle
// with in_ready taken straight from a state flop. Flush kills both entries.
// Optional feature macro: YSYX_22041461_PIPE_PERF_EN adds stall/kill counters.
module ysyx_22041461_pipe_stage #(
  parameter int                 DATA_W   = 96,
  parameter logic [DATA_W-1:0]  RST_DATA = {32'h0, 64'h0000_0000_8000_0000}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef YSYX_22041461_PIPE_PERF_EN
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       kill_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  // Occupancy encoding: bit 0 is main_v, bit 1 is skid_v, so both valids
  // and in_ready come directly from flop outputs.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e              state_r;
  state_e              state_nxt_s;
  logic [DATA_W-1:0]   main_d_r;
  logic [DATA_W-1:0]   skid_d_r;
  logic                main_v_s;
  logic                skid_v_s;
  logic                push_s;
  logic                pop_s;
  logic                load_main_in_s;
  logic                load_main_skid_s;
  logic                load_skid_s;

  assign main_v_s  = state_r[0];
  assign skid_v_s  = state_r[1];
  assign in_ready  = ~skid_v_s;
  assign out_valid = main_v_s;
  assign out_data  = main_d_r;
  assign push_s    = in_valid & ~skid_v_s;
  assign pop_s     = main_v_s & out_ready;

  // Next occupancy and data-load selects; flush overrides every transition.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (push_s) begin
          state_nxt_s    = ST_ONE;
          load_main_in_s = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          state_nxt_s    = ST_ONE;
          load_main_in_s = 1'b1;
        end else if (push_s) begin
          state_nxt_s = ST_FULL;
          load_skid_s = 1'b1;
        end else if (pop_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_ONE;
        end
      end
      ST_FULL: begin
        if (pop_s) begin
          state_nxt_s      = ST_ONE;
          load_main_skid_s = 1'b1;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_nxt_s      = ST_EMPTY;
      load_main_in_s   = 1'b0;
      load_main_skid_s = 1'b0;
      load_skid_s      = 1'b0;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Occupancy register; reset beats flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Main payload register: refilled from upstream or promoted from skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_d_r <= RST_DATA;
    end else if (load_main_in_s) begin
      main_d_r <= in_data;
    end else if (load_main_skid_s) begin
      main_d_r <= skid_d_r;
    end else begin
      main_d_r <= main_d_r;
    end
  end

  // Skid payload register: catches the entry accepted while main is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_d_r <= {DATA_W{1'b0}};
    end else if (load_skid_s) begin
      skid_d_r <= in_data;
    end else begin
      skid_d_r <= skid_d_r;
    end
  end

`ifdef YSYX_22041461_PIPE_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] kill_cnt_r;
  logic [1:0]  kill_add_s;
  logic [32:0] kill_sum_s;

  assign kill_add_s = {1'b0, main_v_s} + {1'b0, skid_v_s};
  assign kill_sum_s = {1'b0, kill_cnt_r} + {31'h0, kill_add_s};
  assign stall_cnt  = stall_cnt_r;
  assign kill_cnt   = kill_cnt_r;

  // Saturating count of cycles where downstream holds off a valid output.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'h0;
    end else if (main_v_s && !out_ready && !flush && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Saturating count of valid entries discarded by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      kill_cnt_r <= 32'h0;
    end else if (flush) begin
      kill_cnt_r <= kill_sum_s[32] ? 32'hFFFF_FFFF : kill_sum_s[31:0];
    end else begin
      kill_cnt_r <= kill_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041461_pipe_stage.sv
// Testbench for ysyx_22041461_pipe_stage: a queue-based occupancy model
// predicts valid/ready/data (and counters when YSYX_22041461_PIPE_PERF_EN
// is defined) for directed scenarios followed by random traffic.
module tb_ysyx_22041461_pipe_stage;

  localparam int         DW = 96;
  localparam logic [DW-1:0] RST_VAL = {32'h0, 64'h0000_0000_8000_0000};

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef YSYX_22041461_PIPE_PERF_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   kill_cnt;
`endif

  int compared;
  int mismatched;

  // Reference model state
  logic [DW-1:0] mq[$];
  longint        m_stall;
  longint        m_kill;

  ysyx_22041461_pipe_stage #(.DATA_W(DW), .RST_DATA(RST_VAL)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef YSYX_22041461_PIPE_PERF_EN
    .out_data  (out_data),
    .stall_cnt (stall_cnt),
    .kill_cnt  (kill_cnt)
`else
    .out_data  (out_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint sat32(input longint v);
    return (v > 64'sh0000_0000_FFFF_FFFF) ? 64'sh0000_0000_FFFF_FFFF : v;
  endfunction

  // One cycle: drive at negedge, check ready before edge, advance model, check after edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic r);
    bit ready_m;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    ready_m = (mq.size() < 2);
    check("in_ready_pre", {95'h0, in_ready}, {95'h0, ready_m});
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_stall = 0;
      m_kill  = 0;
    end else if (fl) begin
      m_kill = sat32(m_kill + mq.size());
      mq.delete();
    end else begin
      if (mq.size() > 0 && !ordy) m_stall = sat32(m_stall + 1);
      if (mq.size() > 0 && ordy) void'(mq.pop_front());
      if (v && ready_m) mq.push_back(d);
    end
    #1;
    check("out_valid", {95'h0, out_valid}, {95'h0, (mq.size() > 0)});
    check("in_ready", {95'h0, in_ready}, {95'h0, (mq.size() < 2)});
    if (mq.size() > 0) check("out_data", out_data, mq[0]);
`ifdef YSYX_22041461_PIPE_PERF_EN
    check("stall_cnt", {64'h0, stall_cnt}, {64'h0, m_stall[31:0]});
    check("kill_cnt", {64'h0, kill_cnt}, {64'h0, m_kill[31:0]});
`endif
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    m_stall    = 0;
    m_kill     = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);

    // Reset held two cycles
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 96'hDEAD, 1'b0, 1'b0, 1'b1);
    check("rst_out_data", out_data, RST_VAL);

    // Streaming 1..8 with out_ready high
    for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: A, B, C with out_ready low, then drain
    step(1'b1, 96'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'hB, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'hC, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'hC, 1'b0, 1'b0, 1'b0);
    check("bp_head_A", out_data, 96'hA);
    step(1'b1, 96'hC, 1'b1, 1'b0, 1'b0);
    check("bp_head_B", out_data, 96'hB);
    step(1'b1, 96'hC, 1'b1, 1'b0, 1'b0);
    check("bp_head_C", out_data, 96'hC);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while FULL with a simultaneous push
    step(1'b1, 96'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h33, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_empty", {95'h0, out_valid}, 96'h0);

    // Reset and flush together while ONE
    step(1'b1, 96'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 96'h55, 1'b0, 1'b1, 1'b1);
    check("rst_flush_data", out_data, RST_VAL);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), rnd_data(), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 99) == 0));
    end

`ifdef YSYX_22041461_PIPE_PERF_EN
    // Stall counter saturation
    step(1'b1, 96'h77, 1'b0, 1'b0, 1'b0);
    force dut.stall_cnt_r = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_r;
    m_stall = 64'sh0000_0000_FFFF_FFFE;
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("stall_sat", {64'h0, stall_cnt}, {64'h0, 32'hFFFF_FFFF});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
